rms_mean_square: RTL and testbench

// Front end of the RMS calculator, directly upstream of the sqrt stage. Squares each signed

---
 rtl/rms_mean_square.sv | 80 ++++++++
 tb/tb_rms_mean_square.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rms_mean_square.sv
// Mean-square front end of the RMS calculator: squares signed samples, sums a
// power-of-two window of valid samples and emits sum >> LOG2_WINDOW with a one-cycle pulse.
module rms_mean_square #(
  parameter int SAMPLE_BITS = 32,
  parameter int LOG2_WINDOW = 8,
  parameter int OUTPUT_BITS = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SAMPLE_BITS-1:0] sample,
  input  logic                   sample_valid,
  input  logic                   clear,
  output logic [OUTPUT_BITS-1:0] radicand,
  output logic                   mean_valid,
  output logic [LOG2_WINDOW-1:0] sample_count
);

  localparam int SQ_BITS  = 2 * SAMPLE_BITS;
  localparam int ACC_BITS = SQ_BITS + LOG2_WINDOW;
  localparam logic [LOG2_WINDOW-1:0] LAST_IDX = '1;

  logic signed [SQ_BITS-1:0] sample_ext;
  logic        [SQ_BITS-1:0] sq_next;
  logic        [SQ_BITS-1:0] sq;
  logic                      sq_vld;
  logic                      sq_last;
  logic        [ACC_BITS-1:0] acc;
  logic        [ACC_BITS-1:0] sum;
  logic        [SQ_BITS-1:0] mean;

  // Sign-extend before multiplying so the most-negative sample squares exactly.
  assign sample_ext = {{SAMPLE_BITS{sample[SAMPLE_BITS-1]}}, sample};
  assign sq_next    = SQ_BITS'(sample_ext * sample_ext);

  // Stage 1: square and window position.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sq           <= '0;
      sq_vld       <= 1'b0;
      sq_last      <= 1'b0;
      sample_count <= '0;
    end else if (sample_valid) begin
      sq           <= sq_next;
      sq_vld       <= 1'b1;
      sq_last      <= (sample_count == LAST_IDX);
      sample_count <= sample_count + LOG2_WINDOW'(1);
    end else begin
      sq_vld       <= 1'b0;
      sq_last      <= 1'b0;
    end
  end

  assign sum  = acc + ACC_BITS'(sq);
  assign mean = sum[ACC_BITS-1:LOG2_WINDOW];

  // Stage 2: accumulate; the closing sample restarts acc at zero so the next window's first add is clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      radicand   <= '0;
      mean_valid <= 1'b0;
    end else if (clear) begin
      acc        <= '0;
      mean_valid <= 1'b0;
    end else begin
      mean_valid <= 1'b0;
      if (sq_vld) begin
        if (sq_last) begin
          radicand   <= OUTPUT_BITS'(mean);
          mean_valid <= 1'b1;
          acc        <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_rms_mean_square.sv
// Self-checking bench for rms_mean_square with a 4-sample window: directed table of
// corner sequences followed by randomized traffic against a window-sum reference model.
module tb_rms_mean_square;

  localparam int SB = 32;
  localparam int LW = 2;
  localparam int OB = 64;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [SB-1:0] sample;
  logic          sample_valid;
  logic          clear;
  logic [OB-1:0] radicand;
  logic          mean_valid;
  logic [LW-1:0] sample_count;

  rms_mean_square #(.SAMPLE_BITS(SB), .LOG2_WINDOW(LW), .OUTPUT_BITS(OB)) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid), .clear(clear),
    .radicand(radicand), .mean_valid(mean_valid), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        r;
    logic        c;
    logic        v;
    int          s;
    logic        mv;
    logic [63:0] rad;
    logic [1:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the samples of the open window, plus a mean that is due one edge later.
  int          win[$];
  logic        m_pend = 1'b0;
  logic [63:0] m_pend_val = '0;
  logic        m_mv = 1'b0;
  logic [63:0] m_rad = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, c, v, input int s, input logic mv,
                     input logic [63:0] rad, input logic [1:0] cnt);
    vec_t e;
    e.r = r; e.c = c; e.v = v; e.s = s; e.mv = mv; e.rad = rad; e.cnt = cnt;
    tbl.push_back(e);
  endtask

  task automatic model_step(input logic r, c, v, input int s);
    logic [65:0] tot;
    if (r || c) begin
      win.delete();
      m_pend = 1'b0;
      m_mv   = 1'b0;
      if (r) m_rad = '0;
    end else begin
      m_mv = m_pend;
      if (m_pend) m_rad = m_pend_val;
      m_pend = 1'b0;
      if (v) begin
        win.push_back(s);
        if (win.size() == N) begin
          tot = '0;
          foreach (win[i]) tot += 66'(longint'(win[i]) * longint'(win[i]));
          m_pend_val = 64'(tot / N);
          m_pend     = 1'b1;
          win.delete();
        end
      end
    end
  endtask

  task automatic apply(input logic r, c, v, input int s);
    rst = r; clear = c; sample_valid = v; sample = s;
    model_step(r, c, v, s);
    @(posedge clk);
    #1;
  endtask

  localparam int MOST_NEG = 32'sh8000_0000;

  initial begin
    rst = 1'b1; clear = 1'b0; sample_valid = 1'b0; sample = '0;

    //   r  c  v  sample     mv rad        cnt
    add(1, 0, 0, 0,         0, 0,         0);   // reset
    add(0, 0, 1, 3,         0, 0,         1);   // 3,-3,3,-3
    add(0, 0, 1, -3,        0, 0,         2);
    add(0, 0, 1, 3,         0, 0,         3);
    add(0, 0, 1, -3,        0, 0,         0);
    add(0, 0, 0, 0,         1, 9,         0);
    add(0, 0, 0, 0,         0, 9,         0);
    add(0, 0, 1, 1,         0, 9,         1);   // 1,2,3,4 -> 30>>2
    add(0, 0, 1, 2,         0, 9,         2);
    add(0, 0, 1, 3,         0, 9,         3);
    add(0, 0, 1, 4,         0, 9,         0);
    add(0, 0, 0, 0,         1, 7,         0);
    add(0, 0, 1, 5,         0, 7,         1);   // back-to-back windows
    add(0, 0, 1, 5,         0, 7,         2);
    add(0, 0, 1, 5,         0, 7,         3);
    add(0, 0, 1, 5,         0, 7,         0);
    add(0, 0, 1, 2,         1, 25,        1);
    add(0, 0, 1, 2,         0, 25,        2);
    add(0, 0, 1, 2,         0, 25,        3);
    add(0, 0, 1, 2,         0, 25,        0);
    add(0, 0, 0, 0,         1, 4,         0);
    add(0, 0, 1, 10,        0, 4,         1);   // gapped valid
    add(0, 0, 0, 0,         0, 4,         1);
    add(0, 0, 1, 10,        0, 4,         2);
    add(0, 0, 0, 0,         0, 4,         2);
    add(0, 0, 1, 10,        0, 4,         3);
    add(0, 0, 0, 0,         0, 4,         3);
    add(0, 0, 1, 10,        0, 4,         0);
    add(0, 0, 0, 0,         1, 100,       0);
    add(0, 0, 0, 0,         0, 100,       0);
    add(0, 0, 1, 7,         0, 100,       1);   // partial window flushed
    add(0, 0, 1, 7,         0, 100,       2);
    add(0, 1, 0, 0,         0, 100,       0);
    add(0, 0, 1, 1,         0, 100,       1);
    add(0, 0, 1, 1,         0, 100,       2);
    add(0, 0, 1, 1,         0, 100,       3);
    add(0, 0, 1, 1,         0, 100,       0);
    add(0, 0, 0, 0,         1, 1,         0);
    add(0, 0, 1, 2,         0, 1,         1);   // clear with 4th sample
    add(0, 0, 1, 2,         0, 1,         2);
    add(0, 0, 1, 2,         0, 1,         3);
    add(0, 1, 1, 2,         0, 1,         0);
    add(0, 0, 0, 0,         0, 1,         0);
    add(0, 0, 1, 3,         0, 1,         1);   // clear while last square is in stage 2
    add(0, 0, 1, 3,         0, 1,         2);
    add(0, 0, 1, 3,         0, 1,         3);
    add(0, 0, 1, 3,         0, 1,         0);
    add(0, 1, 0, 0,         0, 1,         0);
    add(0, 0, 0, 0,         0, 1,         0);
    add(0, 0, 1, MOST_NEG,  0, 1,         1);   // most-negative sample
    add(0, 0, 1, MOST_NEG,  0, 1,         2);
    add(0, 0, 1, MOST_NEG,  0, 1,         3);
    add(0, 0, 1, MOST_NEG,  0, 1,         0);
    add(0, 0, 0, 0,         1, 64'h4000_0000_0000_0000, 0);
    add(0, 0, 1, 6,         0, 64'h4000_0000_0000_0000, 1);
    add(0, 0, 1, 6,         0, 64'h4000_0000_0000_0000, 2);
    add(1, 0, 1, 6,         0, 0,         0);   // reset mid-window
    add(0, 0, 1, 6,         0, 0,         1);
    add(0, 0, 1, 6,         0, 0,         2);
    add(0, 0, 1, 6,         0, 0,         3);
    add(0, 0, 1, 6,         0, 0,         0);
    add(0, 0, 0, 0,         1, 36,        0);
    add(0, 0, 0, 0,         0, 36,        0);

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].s);
      check($sformatf("row%0d mean_valid", i), 64'(mean_valid), 64'(tbl[i].mv));
      check($sformatf("row%0d radicand", i), radicand, tbl[i].rad);
      check($sformatf("row%0d sample_count", i), 64'(sample_count), 64'(tbl[i].cnt));
    end

    for (int i = 0; i < 2000; i++) begin
      logic r, c, v;
      int   s;
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       s = MOST_NEG;
        1:       s = 32'sh7fff_ffff;
        2:       s = $urandom_range(0, 40) - 20;
        default: s = int'($urandom);
      endcase
      apply(r, c, v, s);
      check($sformatf("rand%0d mean_valid", i), 64'(mean_valid), 64'(m_mv));
      check($sformatf("rand%0d radicand", i), radicand, m_rad);
      check($sformatf("rand%0d sample_count", i), 64'(sample_count), 64'(win.size()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
